// File: rtl/fifo_wr_ingress.sv
// -----------------------------------------------------------------------------
// fifo_wr_ingress
//
// Write-side ingress stage placed directly upstream of the write-pointer/full
// block of an asynchronous FIFO. A producer stream is absorbed into a 2-entry
// skid buffer. The full flag from the pointer block is registered, so it
// arrives one cycle late. The skid buffer makes sure that delay never loses
// data. The buffer head is issued to the pointer block and the dual-port RAM
// whenever full is low.
//
// Optional occupancy reporting is built only when the macro
// FIFO_WR_INGRESS_ALMOST_FULL_EN is defined. Otherwise wlevel and almost_full
// are tied to 0, and the ports are kept in both builds.
//
// Handshake: a beat transfers on a rising wclk edge where s_valid and s_ready
// are both high. s_ready is decoded from registered state only. It does not
// depend on s_valid or full in the same cycle.
//
// Ports
//   wclk        in   write-domain clock (rising edge)
//   rst         in   synchronous active-high reset
//   s_valid     in   producer data valid
//   s_data      in   producer data [DATA_WIDTH]
//   s_ready     out  ingress can accept s_data this cycle
//   full        in   registered full flag from the write-pointer block
//   wptr        in   gray write pointer (next value) [ADDR_WIDTH+1]
//   rptr_sync   in   gray read pointer synchronized into wclk [ADDR_WIDTH+1]
//   winc        out  write strobe to the write-pointer block
//   wen         out  RAM write enable (same as winc)
//   wdata       out  RAM write data, the skid-buffer head [DATA_WIDTH]
//   wlevel      out  FIFO occupancy 0..DEPTH [ADDR_WIDTH+1]
//   almost_full out  wlevel >= AF_THRESH
//   stall_cnt   out  saturating count of cycles held back by full [16]
// -----------------------------------------------------------------------------
module fifo_wr_ingress #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic                  winc,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  almost_full,
  output logic [15:0]           stall_cnt
);

  localparam int PW = ADDR_WIDTH + 1;

  // Skid buffer state
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_cnt;
  // Low during reset and high from the first cycle after it. This keeps
  // s_ready low while rst is asserted without a combinational path from rst.
  logic                  r_ready_en;
  logic [15:0]           r_stall;

  logic w_push;
  logic w_pop;
  logic w_not_empty;

  assign w_not_empty = (r_cnt != 2'd0);
  assign s_ready     = r_ready_en & (r_cnt != 2'd2);
  assign w_push      = s_valid & s_ready;
  // The only combinational input into winc is full. The head issues in the
  // same cycle that full drops.
  assign w_pop       = w_not_empty & ~full;
  assign winc        = w_pop;
  assign wen         = w_pop;
  assign wdata       = r_buf[r_head];
  assign stall_cnt   = r_stall;

  always_ff @(posedge wclk) begin
    if (rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
      r_ready_en <= 1'b0;
      r_stall    <= 16'd0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_buf[r_tail] <= s_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      // A push and a pop in the same cycle leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_not_empty && full && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

`ifdef FIFO_WR_INGRESS_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);

  // Gray to binary: the MSB passes through, and each lower bit is the XOR of
  // the decoded bit above it with its own gray bit.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_diff;
  logic [PW-1:0] r_wlevel;
  logic          r_af;

  assign w_wbin = gray2bin(wptr);
  assign w_rbin = gray2bin(rptr_sync);
  // The pointers carry one extra wrap bit. Modulo-2^PW subtraction handles
  // pointer wrap and reports a completely full FIFO as DEPTH, not 0.
  assign w_diff = w_wbin - w_rbin;

  always_ff @(posedge wclk) begin
    if (rst) begin
      r_wlevel <= '0;
      r_af     <= 1'b0;
    end else begin
      r_wlevel <= w_diff;
      r_af     <= (w_diff >= AF_LIM);
    end
  end

  assign wlevel      = r_wlevel;
  assign almost_full = r_af;
`else
  logic w_unused_ptrs;
  assign w_unused_ptrs = ^{wptr, rptr_sync};
  assign wlevel        = '0;
  assign almost_full   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ingress
//
// Self-checking bench for fifo_wr_ingress with the default parameters
// (DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6).
//
// A negedge monitor keeps the scoreboard. Each accepted beat is pushed onto
// exp_q, and each winc pops the queue and compares wdata with the popped
// value. The occupancy vectors come from a table. Reset, backpressure, reset
// during a transfer and stall saturation are written out by hand.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ingress;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int PW = AW + 1;

  logic          wclk;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          full;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr_sync;
  logic          winc;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [PW-1:0] wlevel;
  logic          almost_full;
  logic [15:0]   stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  fifo_wr_ingress #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (6)
  ) dut (
    .wclk       (wclk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .full       (full),
    .wptr       (wptr),
    .rptr_sync  (rptr_sync),
    .winc       (winc),
    .wen        (wen),
    .wdata      (wdata),
    .wlevel     (wlevel),
    .almost_full(almost_full),
    .stall_cnt  (stall_cnt)
  );

  // Clock and reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Helpers
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic send(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
  endtask

  // Scoreboard monitor. It samples mid-cycle, when all inputs are stable.
  always @(negedge wclk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (full) chk("winc_while_full", {31'd0, winc}, 32'd0);
      if (winc) begin
        chk("wen_eq_winc", {31'd0, wen}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("sb_wdata", {24'd0, wdata}, {24'd0, exp_q.pop_front()});
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  typedef struct {
    logic [PW-1:0] wp_bin;
    logic [PW-1:0] rp_bin;
    logic [PW-1:0] exp_lvl;
    logic          exp_af;
  } occ_vec_t;

  occ_vec_t occ_tbl [8];

  initial begin
    // Occupancy vectors (binary pointers; the bench applies gray coding)
    occ_tbl[0] = '{4'd9,  4'd2,  4'd7, 1'b1};
    occ_tbl[1] = '{4'd1,  4'd15, 4'd2, 1'b0};  // pointer wrap
    occ_tbl[2] = '{4'd8,  4'd0,  4'd8, 1'b1};  // exactly DEPTH
    occ_tbl[3] = '{4'd0,  4'd8,  4'd8, 1'b1};  // DEPTH across the wrap
    occ_tbl[4] = '{4'd5,  4'd0,  4'd5, 1'b0};  // just below threshold
    occ_tbl[5] = '{4'd6,  4'd0,  4'd6, 1'b1};  // exactly threshold
    occ_tbl[6] = '{4'd12, 4'd12, 4'd0, 1'b0};  // empty
    occ_tbl[7] = '{4'd3,  4'd14, 4'd5, 1'b0};  // wrap, below threshold

    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; full = 1'b0;
    wptr = '0; rptr_sync = '0;

    // 1. Reset held for 3 cycles with s_valid high
    repeat (3) tick();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_winc", {31'd0, winc}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    chk("rst_wlevel", {28'd0, wlevel}, 32'd0);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    rst = 1'b0; s_valid = 1'b0;
    tick();
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_winc", {31'd0, winc}, 32'd0);

    // 2. Streaming 0x01..0x10 with full low
    for (int i = 1; i <= 16; i++) begin
      send(8'(i));
      #1;
      chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
      tick();
      chk("stream_winc", {31'd0, winc}, 32'd1);
      chk("stream_wdata", {24'd0, wdata}, i);
    end
    s_valid = 1'b0;
    tick();
    chk("stream_drain_winc", {31'd0, winc}, 32'd0);
    chk("stream_stall", {16'd0, stall_cnt}, 32'd0);

    // 3. Backpressure
    full = 1'b1;
    send(8'hA0);
    tick();
    chk("bp_a0_s_ready", {31'd0, s_ready}, 32'd1);
    chk("bp_a0_stall", {16'd0, stall_cnt}, 32'd0);
    send(8'hA1);
    tick();
    chk("bp_stall_1", {16'd0, stall_cnt}, 32'd1);
    send(8'hA2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
      chk("bp_winc_low", {31'd0, winc}, 32'd0);
      tick();
      chk("bp_stall_inc", {16'd0, stall_cnt}, 32'(2 + k));
    end
    full = 1'b0;
    #1;
    chk("bp_release_winc", {31'd0, winc}, 32'd1);
    chk("bp_release_wdata", {24'd0, wdata}, 32'hA0);
    chk("bp_release_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    chk("bp_a1_wdata", {24'd0, wdata}, 32'hA1);
    chk("bp_a1_s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    chk("bp_a2_winc", {31'd0, winc}, 32'd1);
    chk("bp_a2_wdata", {24'd0, wdata}, 32'hA2);
    tick();
    chk("bp_empty_winc", {31'd0, winc}, 32'd0);
    chk("bp_stall_hold", {16'd0, stall_cnt}, 32'd4);

    // 4. Occupancy vectors
    for (int v = 0; v < 8; v++) begin
      wptr      = bin2gray(occ_tbl[v].wp_bin);
      rptr_sync = bin2gray(occ_tbl[v].rp_bin);
      tick();
`ifdef FIFO_WR_INGRESS_ALMOST_FULL_EN
      chk($sformatf("occ_wlevel[%0d]", v), {28'd0, wlevel}, {28'd0, occ_tbl[v].exp_lvl});
      chk($sformatf("occ_af[%0d]", v), {31'd0, almost_full}, {31'd0, occ_tbl[v].exp_af});
`else
      chk($sformatf("occ_wlevel_off[%0d]", v), {28'd0, wlevel}, 32'd0);
      chk($sformatf("occ_af_off[%0d]", v), {31'd0, almost_full}, 32'd0);
`endif
    end

    // 5. Reset during a transfer, with the buffer full and full held high
    full = 1'b1;
    send(8'hB0);
    tick();
    send(8'hB1);
    tick();
    send(8'hB2);
    #1;
    chk("mid_s_ready_full_buf", {31'd0, s_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    #1;
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_wdata", {24'd0, wdata}, 32'd0);
    chk("mid_rst_wlevel", {28'd0, wlevel}, 32'd0);
    full = 1'b0;
    #1;
    chk("mid_rst_winc", {31'd0, winc}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_rst_no_stale", {31'd0, winc}, 32'd0);
    end
    chk("mid_rst_s_ready_back", {31'd0, s_ready}, 32'd1);

    // 6. Stall counter saturation
    full = 1'b1;
    send(8'hC3);
    tick();
    s_valid = 1'b0;
    repeat (70000) @(posedge wclk);
    #1;
    chk("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
    tick();
    chk("sat_stall_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    full = 1'b0;
    #1;
    chk("sat_release_wdata", {24'd0, wdata}, 32'hC3);
    tick();
    tick();
    chk("sat_drained_winc", {31'd0, winc}, 32'd0);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
